// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite interconnect types: arbiter state encoding, response codes, field widths.
// Pure declarations; no logic, latency or flow control of its own.
package axi_lite_pkg;

    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi_lite_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after (last+1) mod N, wrapping.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
    parameter int N    = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int w_cand;

    // Scan farthest-first so the nearest requester after 'last' is the final write.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        w_cand = 0;
        for (int k = N; k >= 1; k--) begin
            w_cand = (int'(last) + k) % N;
            if (req[w_cand]) begin
                idx   = IDX_W'(w_cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// N-to-1 AXI-Lite write arbiter: round-robin on AW valid, grant held from AW through B, one transaction in flight.
// Latency: 1 cycle awvalid->s_awvalid, 3 cycles minimum per write; losers and the owner outside XFER/RESP see ready=0.
module axi_lite_wr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [N-1:0]          m_awvalid,
    input  logic [N*ADDR_W-1:0]   m_awaddr,
    input  logic [N*PROT_W-1:0]   m_awprot,
    output logic [N-1:0]          m_awready,
    input  logic [N-1:0]          m_wvalid,
    input  logic [N*DATA_W-1:0]   m_wdata,
    input  logic [N*STRB_W-1:0]   m_wstrb,
    output logic [N-1:0]          m_wready,
    output logic [N-1:0]          m_bvalid,
    output logic [N*RESP_W-1:0]   m_bresp,
    input  logic [N-1:0]          m_bready,

    output logic                  s_awvalid,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [PROT_W-1:0]     s_awprot,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [STRB_W-1:0]     s_wstrb,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [RESP_W-1:0]     s_bresp,
    output logic                  s_bready,

    output logic [N-1:0]          grant,
    output logic                  busy
);

    arb_state_t       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last;
    logic             r_aw_done;
    logic             r_w_done;

    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic             w_in_xfer;
    logic             w_in_resp;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_both_done;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .req   (m_awvalid),
        .last  (r_last),
        .idx   (w_pick_idx),
        .valid (w_pick_vld)
    );

    assign w_in_xfer = (r_state == XFER);
    assign w_in_resp = (r_state == RESP);

    // Payloads follow sel unconditionally; only the valids are qualified by state.
    assign s_awaddr  = m_awaddr[r_sel*ADDR_W +: ADDR_W];
    assign s_awprot  = m_awprot[r_sel*PROT_W +: PROT_W];
    assign s_wdata   = m_wdata[r_sel*DATA_W +: DATA_W];
    assign s_wstrb   = m_wstrb[r_sel*STRB_W +: STRB_W];

    assign s_awvalid = w_in_xfer & m_awvalid[r_sel] & ~r_aw_done;
    assign s_wvalid  = w_in_xfer & m_wvalid[r_sel]  & ~r_w_done;
    assign s_bready  = w_in_resp & m_bready[r_sel];

    assign w_aw_hs     = s_awvalid & s_awready;
    assign w_w_hs      = s_wvalid  & s_wready;
    assign w_b_hs      = s_bvalid  & s_bready;
    assign w_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    assign m_bresp = {N{s_bresp}};
    assign busy    = (r_state != IDLE);

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        grant     = '0;
        if (w_in_xfer) begin
            m_awready[r_sel] = s_awready & ~r_aw_done;
            m_wready[r_sel]  = s_wready  & ~r_w_done;
        end
        if (w_in_resp) begin
            m_bvalid[r_sel] = s_bvalid;
        end
        if (r_state != IDLE) begin
            grant[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_last    <= SEL_W'(N - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_sel   <= w_pick_idx;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_both_done) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_last    <= r_sel;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Directed bench for axi_lite_wr_arbiter: per-cycle master/slave models driven on negedge, sampled 1ns later.
// Single-transaction vector table plus hand-written round-robin, contention and reset sequences.
module tb_axi_lite_wr_arbiter;

    localparam int N = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     m_awvalid;
    logic [N*32-1:0]  m_awaddr;
    logic [N*3-1:0]   m_awprot;
    logic [N-1:0]     m_awready;
    logic [N-1:0]     m_wvalid;
    logic [N*32-1:0]  m_wdata;
    logic [N*4-1:0]   m_wstrb;
    logic [N-1:0]     m_wready;
    logic [N-1:0]     m_bvalid;
    logic [N*2-1:0]   m_bresp;
    logic [N-1:0]     m_bready;
    logic             s_awvalid;
    logic [31:0]      s_awaddr;
    logic [2:0]       s_awprot;
    logic             s_awready;
    logic             s_wvalid;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic             s_wready;
    logic             s_bvalid;
    logic [1:0]       s_bresp;
    logic             s_bready;
    logic [N-1:0]     grant;
    logic             busy;

    axi_lite_wr_arbiter #(.N(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // master model
    logic [N-1:0] aw_pend, w_pend;
    logic [31:0]  mst_addr[N];
    logic [31:0]  mst_data[N];
    logic [3:0]   mst_strb[N];
    int           aw_delay[N];
    int           w_delay[N];
    int           rem[N];
    int           b_cnt[N];
    int           b_cyc[N];
    logic [1:0]   b_resp[N];
    logic         rst_drv;

    // slave model
    logic         sl_aw, sl_w;
    int           sl_aw_cnt, sl_w_cnt;
    logic [31:0]  sl_addr, sl_data;
    logic [3:0]   sl_strb;
    logic [2:0]   sl_prot;
    int           sl_bdly, sl_bcnt, sl_aw_stall;
    logic [1:0]   sl_resp;

    // monitors
    int           ncyc, busy_cyc, first_mav, first_sav;
    int           overlap_err, leak_err, early_err;
    logic [N-1:0] prev_grant, bv_seen;
    int           grant_log[$];
    int           grant_cyc[$];

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        int          awd;
        int          wd;
        int          bdly;
        int          awstall;
        int          exp_busy;
    } vec_t;

    vec_t vt[6];
    int   exp_rr[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic rem_zero();
        logic z;
        z = 1'b1;
        for (int i = 0; i < N; i++) if (rem[i] != 0) z = 1'b0;
        return z;
    endfunction

    task automatic cycle();
        logic bhs;
        @(negedge clk);
        rst = rst_drv;
        for (int i = 0; i < N; i++) begin
            m_awvalid[i]       = aw_pend[i] && (aw_delay[i] == 0);
            m_wvalid[i]        = w_pend[i] && (w_delay[i] == 0);
            m_awaddr[i*32 +: 32] = mst_addr[i];
            m_wdata[i*32 +: 32]  = mst_data[i];
            m_wstrb[i*4 +: 4]    = mst_strb[i];
            m_awprot[i*3 +: 3]   = 3'(i);
        end
        m_bready  = '1;
        s_awready = (sl_aw_stall == 0);
        s_wready  = 1'b1;
        s_bvalid  = sl_aw && sl_w && (sl_bcnt == 0);
        s_bresp   = sl_resp;
        #1;
        ncyc++;
        if (busy) busy_cyc++;
        if (!$onehot0(grant)) overlap_err++;
        if (((m_awready | m_wready | m_bvalid) & ~grant) != '0) leak_err++;
        if (s_bready && !(sl_aw && sl_w)) early_err++;
        if (grant != '0 && prev_grant == '0) begin
            grant_log.push_back(oh2idx(grant));
            grant_cyc.push_back(ncyc);
        end
        prev_grant = grant;
        if (m_awvalid != '0 && first_mav < 0) first_mav = ncyc;
        if (s_awvalid && first_sav < 0) first_sav = ncyc;
        bv_seen |= m_bvalid;
        bhs = s_bvalid && s_bready;
        if (bhs) begin
            sl_aw = 1'b0; sl_w = 1'b0; sl_bcnt = sl_bdly;
        end else if (sl_aw && sl_w && sl_bcnt > 0) begin
            sl_bcnt--;
        end
        if (s_awvalid && s_awready) begin
            sl_aw = 1'b1; sl_aw_cnt++; sl_addr = s_awaddr; sl_prot = s_awprot;
        end else if (s_awvalid && sl_aw_stall > 0) begin
            sl_aw_stall--;
        end
        if (s_wvalid && s_wready) begin
            sl_w = 1'b1; sl_w_cnt++; sl_data = s_wdata; sl_strb = s_wstrb;
        end
        for (int i = 0; i < N; i++) begin
            if (m_awvalid[i] && m_awready[i]) aw_pend[i] = 1'b0;
            else if (aw_pend[i] && aw_delay[i] > 0) aw_delay[i]--;
            if (m_wvalid[i] && m_wready[i]) w_pend[i] = 1'b0;
            else if (w_pend[i] && w_delay[i] > 0) w_delay[i]--;
            if (m_bvalid[i] && m_bready[i]) begin
                b_cnt[i]++;
                b_resp[i] = m_bresp[i*2 +: 2];
                b_cyc[i]  = ncyc;
                if (rem[i] > 0) begin
                    rem[i]--; aw_pend[i] = 1'b1; w_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int awd, input int wd);
        mst_addr[m] = a; mst_data[m] = d; mst_strb[m] = s;
        aw_delay[m] = awd; w_delay[m] = wd;
        aw_pend[m] = 1'b1; w_pend[m] = 1'b1;
    endtask

    task automatic run_idle(input int max, input string nm);
        logic done;
        done = 1'b0;
        for (int k = 0; k < max && !done; k++) begin
            cycle();
            done = (aw_pend == '0) && (w_pend == '0) && !busy && rem_zero();
        end
        chk({nm, " completes"}, 32'(done), 32'd1);
    endtask

    task automatic clear_mon();
        grant_log.delete(); grant_cyc.delete();
        first_mav = -1; first_sav = -1; bv_seen = '0; busy_cyc = 0;
        sl_aw_cnt = 0; sl_w_cnt = 0;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " grant"},     32'(grant),     32'd0);
        chk({nm, " busy"},      32'(busy),      32'd0);
        chk({nm, " m_awready"}, 32'(m_awready), 32'd0);
        chk({nm, " m_wready"},  32'(m_wready),  32'd0);
        chk({nm, " m_bvalid"},  32'(m_bvalid),  32'd0);
        chk({nm, " s_awvalid"}, 32'(s_awvalid), 32'd0);
        chk({nm, " s_wvalid"},  32'(s_wvalid),  32'd0);
        chk({nm, " s_bready"},  32'(s_bready),  32'd0);
    endtask

    initial begin
        int m, b0;
        rst = 1'b1; rst_drv = 1'b1;
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_awaddr = '0; m_wdata = '0;
        m_wstrb = '0; m_awprot = '0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
        aw_pend = '0; w_pend = '0; prev_grant = '0;
        for (int i = 0; i < N; i++) begin
            mst_addr[i] = '0; mst_data[i] = '0; mst_strb[i] = '0; aw_delay[i] = 0; w_delay[i] = 0;
            rem[i] = 0; b_cnt[i] = 0; b_cyc[i] = 0; b_resp[i] = '0;
        end
        sl_aw = 1'b0; sl_w = 1'b0; sl_addr = '0; sl_data = '0; sl_strb = '0; sl_prot = '0;
        sl_bdly = 0; sl_bcnt = 0; sl_aw_stall = 0; sl_resp = 2'b00;
        ncyc = 0; overlap_err = 0; leak_err = 0; early_err = 0;
        clear_mon();

        //                mst addr          data          strb  resp   awd wd bdly stall busy
        vt[0] = '{2, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0, 0, 2};
        vt[1] = '{0, 32'h0000_0020, 32'h1234_5678, 4'h3, 2'b10, 0, 0, 0, 0, 2};
        vt[2] = '{3, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'h8, 2'b00, 0, 0, 2, 0, 4};
        vt[3] = '{1, 32'h0000_0044, 32'h0F0F_0F0F, 4'hF, 2'b00, 0, 3, 0, 0, 4};
        vt[4] = '{2, 32'h0000_0080, 32'hCAFE_F00D, 4'hC, 2'b10, 3, 0, 0, 0, 2};
        vt[5] = '{0, 32'h0000_0100, 32'h1122_3344, 4'h1, 2'b00, 0, 0, 0, 2, 4};
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};

        cycle(); cycle();
        chk_idle_outputs("reset");
        rst_drv = 1'b0;

        for (int r = 0; r < 6; r++) begin
            clear_mon();
            m = vt[r].mst;
            sl_resp = vt[r].resp; sl_bdly = vt[r].bdly; sl_bcnt = vt[r].bdly;
            sl_aw_stall = vt[r].awstall;
            b0 = b_cnt[m];
            issue(m, vt[r].addr, vt[r].data, vt[r].strb, vt[r].awd, vt[r].wd);
            run_idle(40, $sformatf("vec%0d", r));
            chk($sformatf("vec%0d grants", r),  32'(grant_log.size()), 32'd1);
            chk($sformatf("vec%0d winner", r),  (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'(m));
            chk($sformatf("vec%0d s_awaddr", r), sl_addr, vt[r].addr);
            chk($sformatf("vec%0d s_awprot", r), 32'(sl_prot), 32'(m));
            chk($sformatf("vec%0d s_wdata", r),  sl_data, vt[r].data);
            chk($sformatf("vec%0d s_wstrb", r),  32'(sl_strb), 32'(vt[r].strb));
            chk($sformatf("vec%0d aw once", r),  32'(sl_aw_cnt), 32'd1);
            chk($sformatf("vec%0d w once", r),   32'(sl_w_cnt), 32'd1);
            chk($sformatf("vec%0d b count", r),  32'(b_cnt[m] - b0), 32'd1);
            chk($sformatf("vec%0d bresp", r),    32'(b_resp[m]), 32'(vt[r].resp));
            chk($sformatf("vec%0d bvalid idx", r), 32'(bv_seen), 32'(1 << m));
            chk($sformatf("vec%0d busy cycles", r), 32'(busy_cyc), 32'(vt[r].exp_busy));
            chk($sformatf("vec%0d aw latency", r), 32'(first_sav - first_mav), 32'd1);
        end
        sl_resp = 2'b00; sl_bdly = 0; sl_bcnt = 0; sl_aw_stall = 0;

        // Fresh reset, then all four request continuously: two full rotations.
        rst_drv = 1'b1; cycle(); cycle(); rst_drv = 1'b0;
        clear_mon();
        for (int i = 0; i < N; i++) begin
            issue(i, 32'h1000 + 32'(i), 32'h5500 + 32'(i), 4'hF, 0, 0);
            rem[i] = 1;
        end
        run_idle(100, "rr");
        chk("rr grants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rr order %0d", k),
                (grant_log.size() > k) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(exp_rr[k]));
        chk("rr aw count", 32'(sl_aw_cnt), 32'd8);
        chk("rr busy cycles", 32'(busy_cyc), 32'd16);

        // Master 1 owns with a 5-cycle B stall; master 3 waits then wins after the IDLE cycle.
        clear_mon();
        sl_bdly = 5; sl_bcnt = 5;
        b0 = b_cnt[3];
        issue(1, 32'h2000, 32'h0000_0001, 4'hF, 0, 0);
        cycle();
        issue(3, 32'h3000, 32'h0000_0003, 4'hF, 0, 0);
        run_idle(60, "contend");
        chk("contend grants", 32'(grant_log.size()), 32'd2);
        chk("contend first",  (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd1);
        chk("contend second", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFF_FFFF, 32'd3);
        chk("contend regrant gap", (grant_cyc.size() > 1) ? 32'(grant_cyc[1] - b_cyc[1]) : 32'hFFFF_FFFF, 32'd2);
        chk("contend m3 served", 32'(b_cnt[3] - b0), 32'd1);
        chk("contend busy cycles", 32'(busy_cyc), 32'd14);
        sl_bdly = 0; sl_bcnt = 0;

        // Move 'last' to 0 so a lost reset of 'last' would make master 1 win below.
        clear_mon();
        issue(0, 32'h4000, 32'h0000_0040, 4'hF, 0, 0);
        run_idle(20, "pre-reset");
        chk("pre-reset winner", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);

        // Reset with master 2 mid-XFER: AW accepted, W still outstanding.
        clear_mon();
        issue(2, 32'h5000, 32'h0000_0050, 4'hF, 0, 20);
        for (int k = 0; k < 10 && sl_aw_cnt == 0; k++) cycle();
        chk("midrst aw accepted", 32'(sl_aw_cnt), 32'd1);
        rst_drv = 1'b1; cycle();
        rst_drv = 1'b0; w_delay[2] = 0;
        cycle();
        chk_idle_outputs("midrst");
        w_pend[2] = 1'b0; sl_aw = 1'b0; sl_w = 1'b0;
        clear_mon();
        issue(1, 32'h6001, 32'h0000_0061, 4'hF, 0, 0);
        issue(0, 32'h6000, 32'h0000_0060, 4'hF, 0, 0);
        run_idle(40, "postrst");
        chk("postrst first",  (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);
        chk("postrst second", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFF_FFFF, 32'd1);

        chk("grant onehot0", 32'(overlap_err), 32'd0);
        chk("ready/bvalid only on owner", 32'(leak_err), 32'd0);
        chk("resp only after both handshakes", 32'(early_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
